multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multi-cycle sequencing FSM for the core. It steps each instruction through fetch, decode, execute, memory and writeback, driving the register and PC write enables around the `opcode_t` class produced by `decode_opcode`. It handshakes with instruction and data memory, counts retired instructions, and halts into a sticky trap state on unsupported or illegal instructions.

## Interface
- `TIMEOUT_CYCLES`, 16, wait-cycle limit for a memory ack; used only with `MEM_TIMEOUT_EN`.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode_type`  in  `opcode_t`  instruction class from `decode_opcode`; valid during DECODE.
- `branch_taken`  in  1  comparator result; valid during EXECUTE.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch data valid.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data access is a store.
- `dmem_ack`  in  1  data access complete.
- `ir_we`  out  1  latch the instruction register.
- `pc_we`  out  1  update the PC.
- `pc_sel`  out  2  PC source: 0 = pc+4, 1 = pc+imm (branch/jal), 2 = jalr target.
- `rf_we`  out  1  register file write.
- `wb_sel`  out  2  writeback source: 0 = ALU, 1 = memory, 2 = pc+4.
- `trap`  out  1  sticky halt flag.
- `trap_cause`  out  2  0 = none, 1 = illegal, 2 = system, 3 = timeout.
- `instret`  out  32  retired-instruction count.
- `state`  out  3  debug view of the state register: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.

## Operation
Reset forces:
- state = FETCH, `trap` = 0, `trap_cause` = 0, `instret` = 0, internal class register `op_q` cleared.

All request and enable outputs are Moore/Mealy decodes of the state and `op_q`. They are 0 in every state except where listed below.

- **FETCH**
  - `imem_req` = 1.
  - `ir_we` = `imem_ack` (same cycle).
  - On `imem_ack`, go to DECODE; otherwise stay in FETCH.
- **DECODE** (one cycle)
  - Register `opcode_type` into `op_q`.
  - `system_type` -> TRAP with cause 2.
  - Any value outside the eleven defined classes -> TRAP with cause 1.
  - Otherwise -> EXECUTE.
- **EXECUTE** (one cycle)
  - `load_type` or `store_type` -> MEM.
  - `branch_type`: `pc_we` = 1, `pc_sel` = `branch_taken` ? 1 : 0, retire, go to FETCH.
  - `fence_type`: `pc_we` = 1, `pc_sel` = 0, retire, go to FETCH (treated as a no-op).
  - `lui`, `auipc`, `jal`, `jalr`, `imm_arith_type`, `reg_arith_type` -> WB.
- **MEM**
  - `dmem_req` = 1; `dmem_we` = (`op_q` == `store_type`).
  - On `dmem_ack`, a store does `pc_we` = 1, `pc_sel` = 0, retires and goes to FETCH.
  - On `dmem_ack`, a load goes to WB.
- **WB** (one cycle)
  - `rf_we` = 1.
  - `wb_sel`: 1 for load, 2 for jal/jalr, 0 otherwise.
  - `pc_we` = 1.
  - `pc_sel`: 1 for jal, 2 for jalr, 0 otherwise.
  - Retire, go to FETCH.
- **TRAP**
  - All requests and enables are 0.
  - `trap` = 1 with `trap_cause` held.
  - Exits only on reset.

Retire means `instret` increments by 1 on that clock edge. The counter wraps from 0xFFFF_FFFF to 0.

## Timing
- Cycle counts, assuming ack in the same cycle as the request:
  - ALU, U-type and jump instructions: 4 cycles (F, D, E, W).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch and fence: 3 cycles.
- Each cycle of ack delay adds one cycle.
- A request stays high until its ack arrives. An ack outside its own waiting state is ignored.
- `trap` rises on the edge leaving DECODE (or leaving FETCH/MEM on timeout).
- Reset asserted mid-instruction immediately returns every output to its reset value. Partial work is abandoned and `instret` is not incremented.
- `op_q` changes only in DECODE. All later decisions use `op_q`, never the live `opcode_type`.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A wait counter clears on entry to FETCH or MEM and counts each cycle the request is high without an ack.
  - If no ack arrives after `TIMEOUT_CYCLES` waiting cycles, the next edge goes to TRAP with cause 3 and the request drops.
  - An ack in the final waiting cycle wins over the timeout.
- `MEM_TIMEOUT_EN` undefined:
  - No counter is built and the FSM waits indefinitely.
  - Cause 3 is never produced.

## Test plan
- `reg_arith_type` with immediate acks -> states 0,1,2,4,0.
  - `rf_we` = 1 and `wb_sel` = 0 in WB.
  - `instret` goes 0 -> 1.
- `load_type` with `dmem_ack` delayed 3 cycles -> `dmem_req` high for 4 cycles, `dmem_we` = 0, then WB with `wb_sel` = 1; 8 cycles total.
- `branch_type`:
  - with `branch_taken` = 1 -> `pc_sel` = 1 in EXECUTE, no `rf_we`, 3 cycles;
  - with `branch_taken` = 0 -> `pc_sel` = 0.
- `jalr` -> `wb_sel` = 2 and `pc_sel` = 2 in WB.
- `system_type` -> `trap` = 1, `trap_cause` = 2, `imem_req` stays 0 for 20 cycles, `instret` unchanged.
  - A reset pulse then returns to FETCH with `trap` = 0.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16, hold `imem_ack` = 0 -> TRAP with cause 3 after 16 request cycles.
  - Ack on cycle 16 -> DECODE instead of TRAP.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with sticky trap and retire counter.
// Optional MEM_TIMEOUT_EN adds a bounded wait on instruction/data memory acks.
package multicycle_controller_pkg;

  // Instruction classes as produced by decode_opcode; codes 11..15 are illegal.
  typedef enum logic [3:0] {
    lui            = 4'd0,
    auipc          = 4'd1,
    jal            = 4'd2,
    jalr           = 4'd3,
    branch_type    = 4'd4,
    load_type      = 4'd5,
    store_type     = 4'd6,
    imm_arith_type = 4'd7,
    reg_arith_type = 4'd8,
    fence_type     = 4'd9,
    system_type    = 4'd10
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_TRAP    = 3'd5
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

endpackage

module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  opcode_t     opcode_type,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      r_state;
  state_t      w_next;
  opcode_t     r_op;
  logic [1:0]  r_cause;
  logic [1:0]  w_cause;
  logic [31:0] r_instret;
  logic        w_retire;
  logic        w_timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] r_wait;

  // Waiting cycles seen in the current FETCH/MEM visit; cleared on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else if (w_next != r_state) begin
      r_wait <= '0;
    end else if (r_state == S_FETCH || r_state == S_MEM) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op      <= lui;
      r_cause   <= CAUSE_NONE;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause;
      if (r_state == S_DECODE) r_op <= opcode_type;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_cause  = r_cause;
    w_retire = 1'b0;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'd0;
    rf_we    = 1'b0;
    wb_sel   = 2'd0;
    case (r_state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        if (imem_ack) begin
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode_type)
          system_type: begin
            w_next  = S_TRAP;
            w_cause = CAUSE_SYSTEM;
          end
          lui, auipc, jal, jalr, branch_type, load_type, store_type,
          imm_arith_type, reg_arith_type, fence_type: w_next = S_EXECUTE;
          default: begin
            w_next  = S_TRAP;
            w_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXECUTE: begin
        case (r_op)
          load_type, store_type: w_next = S_MEM;
          branch_type: begin
            pc_we    = 1'b1;
            pc_sel   = branch_taken ? 2'd1 : 2'd0;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          fence_type: begin
            pc_we    = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          default: w_next = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (r_op == store_type);
        if (dmem_ack) begin
          if (r_op == store_type) begin
            pc_we    = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        pc_we    = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
        if (r_op == load_type) wb_sel = 2'd1;
        else if (r_op == jal || r_op == jalr) wb_sel = 2'd2;
        if (r_op == jal) pc_sel = 2'd1;
        else if (r_op == jalr) pc_sel = 2'd2;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_cause;
  assign instret    = r_instret;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expectations are queued at drive time
// and compared at the falling edge. Build with +define+MEM_TIMEOUT_EN to cover the timeout path.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  opcode_t     opcode_type;
  logic        branch_taken, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, trap;
  logic [1:0]  pc_sel, wb_sel, trap_cause;
  logic [31:0] instret;
  logic [2:0]  state;

  multicycle_controller #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .opcode_type(opcode_type), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [9:0]  ctl;
    logic        trp;
    logic [1:0]  cause;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_instret = '0;
  logic [1:0]  m_cause   = '0;
  localparam opcode_t DECOY = system_type;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [9:0] c(input logic imr, ir, dr, dw, pw, rw,
                                   input logic [1:0] ps, ws);
    return {imr, ir, dr, dw, pw, rw, ps, ws};
  endfunction

  function automatic exp_t ex(input logic [2:0] st, input logic [9:0] ctl);
    exp_t e;
    e.st    = st;
    e.ctl   = ctl;
    e.trp   = (st == 3'd5);
    e.cause = m_cause;
    e.ret   = m_instret;
    return e;
  endfunction

  // Falling-edge monitor: pop the oldest expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("ctl", 32'({imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, pc_sel, wb_sel}),
               32'(e.ctl));
      check_eq("trap", 32'({trap, trap_cause}), 32'({e.trp, e.cause}));
      check_eq("instret", instret, e.ret);
    end
  end

  task automatic step(input opcode_t op, input logic bt, ia, da, input exp_t e);
    opcode_type  = op;
    branch_taken = bt;
    imem_ack     = ia;
    dmem_ack     = da;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction: fd fetch-ack wait cycles, md data-ack wait cycles.
  task automatic run_instr(input opcode_t op, input logic tk, input int fd, input int md);
    logic       st_op;
    logic [1:0] ps, ws;
    st_op = (op == store_type);
    for (int i = 0; i < fd; i++) step(DECOY, ~tk, 1'b0, 1'b1, ex(3'd0, c(1,0,0,0,0,0,2'd0,2'd0)));
    step(DECOY, ~tk, 1'b1, 1'b1, ex(3'd0, c(1,1,0,0,0,0,2'd0,2'd0)));
    step(op, ~tk, 1'b1, 1'b1, ex(3'd1, c(0,0,0,0,0,0,2'd0,2'd0)));
    if (op == system_type) begin
      m_cause = 2'd2;
      return;
    end
    if (!(op inside {lui, auipc, jal, jalr, branch_type, load_type, store_type,
                     imm_arith_type, reg_arith_type, fence_type})) begin
      m_cause = 2'd1;
      return;
    end
    if (op == branch_type) begin
      step(DECOY, tk, 1'b1, 1'b1, ex(3'd2, c(0,0,0,0,1,0,{1'b0, tk},2'd0)));
      m_instret++;
      return;
    end
    if (op == fence_type) begin
      step(DECOY, tk, 1'b1, 1'b1, ex(3'd2, c(0,0,0,0,1,0,2'd0,2'd0)));
      m_instret++;
      return;
    end
    step(DECOY, ~tk, 1'b1, 1'b1, ex(3'd2, c(0,0,0,0,0,0,2'd0,2'd0)));
    if (op == load_type || st_op) begin
      for (int i = 0; i < md; i++)
        step(DECOY, ~tk, 1'b1, 1'b0, ex(3'd3, c(0,0,1,st_op,0,0,2'd0,2'd0)));
      step(DECOY, ~tk, 1'b1, 1'b1, ex(3'd3, c(0,0,1,st_op,st_op,0,2'd0,2'd0)));
      if (st_op) begin
        m_instret++;
        return;
      end
    end
    ws = (op == load_type) ? 2'd1 : (op == jal || op == jalr) ? 2'd2 : 2'd0;
    ps = (op == jal) ? 2'd1 : (op == jalr) ? 2'd2 : 2'd0;
    step(DECOY, ~tk, 1'b1, 1'b1, ex(3'd4, c(0,0,0,0,1,1,ps,ws)));
    m_instret++;
  endtask

  task automatic trap_cycles(input int n);
    for (int i = 0; i < n; i++) step(DECOY, 1'b1, 1'b1, 1'b1, ex(3'd5, c(0,0,0,0,0,0,2'd0,2'd0)));
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_state"}, 32'(state), 32'd0);
    check_eq({tag, "_trap"}, 32'({trap, trap_cause}), 32'd0);
    check_eq({tag, "_instret"}, instret, 32'd0);
    check_eq({tag, "_imem_req"}, 32'(imem_req), 32'd1);
    rst       = 1'b0;
    m_instret = '0;
    m_cause   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] bad_code;
    rst          = 1'b1;
    opcode_type  = reg_arith_type;
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
    dmem_ack     = 1'b0;
    @(posedge clk);
    #1;
    reset_pulse("reset");

    run_instr(reg_arith_type, 1'b0, 0, 0);
    run_instr(load_type,      1'b0, 0, 3);
    run_instr(store_type,     1'b0, 0, 0);
    run_instr(branch_type,    1'b1, 0, 0);
    run_instr(branch_type,    1'b0, 0, 0);
    run_instr(jalr,           1'b0, 0, 0);
    run_instr(jal,            1'b1, 0, 0);
    run_instr(fence_type,     1'b0, 0, 0);
    run_instr(lui,            1'b0, 1, 0);
    run_instr(auipc,          1'b1, 0, 0);
    run_instr(imm_arith_type, 1'b0, 2, 0);
    run_instr(store_type,     1'b1, 3, 2);
    run_instr(load_type,      1'b0, 0, 0);

    // Reset arriving mid-load abandons it without retiring.
    step(DECOY, 1'b0, 1'b1, 1'b1, ex(3'd0, c(1,1,0,0,0,0,2'd0,2'd0)));
    step(load_type, 1'b0, 1'b1, 1'b1, ex(3'd1, c(0,0,0,0,0,0,2'd0,2'd0)));
    step(DECOY, 1'b0, 1'b1, 1'b1, ex(3'd2, c(0,0,0,0,0,0,2'd0,2'd0)));
    dmem_ack = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_state", 32'(state), 32'd0);
    check_eq("async_rst_dmem_req", 32'(dmem_req), 32'd0);
    check_eq("async_rst_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    m_instret = '0;
    run_instr(reg_arith_type, 1'b0, 0, 0);

    run_instr(system_type, 1'b0, 0, 0);
    trap_cycles(20);
    reset_pulse("sys_reset");

    run_instr(jalr, 1'b0, 0, 0);
    bad_code = 4'd12;
    run_instr(opcode_t'(bad_code), 1'b0, 0, 0);
    trap_cycles(3);
    reset_pulse("ill_reset");

`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) step(DECOY, 1'b0, 1'b0, 1'b1, ex(3'd0, c(1,0,0,0,0,0,2'd0,2'd0)));
    m_cause = 2'd3;
    trap_cycles(2);
    reset_pulse("to_reset");
    run_instr(reg_arith_type, 1'b0, 15, 0);
    run_instr(load_type,      1'b0, 0, 15);
    run_instr(store_type,     1'b0, 0, 0);
    step(DECOY, 1'b0, 1'b1, 1'b1, ex(3'd0, c(1,1,0,0,0,0,2'd0,2'd0)));
    step(load_type, 1'b0, 1'b1, 1'b1, ex(3'd1, c(0,0,0,0,0,0,2'd0,2'd0)));
    step(DECOY, 1'b0, 1'b1, 1'b1, ex(3'd2, c(0,0,0,0,0,0,2'd0,2'd0)));
    for (int i = 0; i < 16; i++) step(DECOY, 1'b0, 1'b1, 1'b0, ex(3'd3, c(0,0,1,0,0,0,2'd0,2'd0)));
    m_cause = 2'd3;
    trap_cycles(2);
    reset_pulse("mto_reset");
`endif

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
